// File: rtl/ram_seq_ctrl_pkg.sv
// Shared constants and state encoding for the RAM fill/dump sequencer.
package ram_seq_ctrl_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 256;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_PRESENT = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

endpackage

// File: rtl/ram_seq_ctrl.sv
// Block-RAM sequencer: bulk FILL (constant/incrementing) and DUMP (valid/ready
// stream with running checksum) over a wrapping address window.
module ram_seq_ctrl #(
  parameter int ADDR_W = ram_seq_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_seq_ctrl_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_op,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_pattern,
  input  logic              i_inc_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_checksum
);

  import ram_seq_ctrl_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;
  logic              r_inc;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_checksum;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_idx_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_inc_nxt;
  logic              w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_din_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_out_valid_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_checksum_nxt;

  logic [CNT_W-1:0]  w_len_clamped;
  logic [CNT_W-1:0]  w_idx_inc;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_next_word;

  assign w_len_clamped    = (i_len > MAX_CNT) ? MAX_CNT : i_len;
  assign w_idx_inc        = r_idx + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last           = (w_idx_inc == r_cnt);
  assign w_addr_next_word = r_base + w_idx_inc[ADDR_W-1:0];

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_base_nxt      = r_base;
    w_inc_nxt       = r_inc;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_din_nxt   = r_mem_din;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_checksum_nxt  = r_checksum;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_base_nxt = i_base;
          w_inc_nxt  = i_inc_en;
          w_cnt_nxt  = w_len_clamped;
          w_idx_nxt  = {CNT_W{1'b0}};
          // Empty window: straight to FIN, checksum deliberately left alone.
          if (w_len_clamped == {CNT_W{1'b0}}) begin
            w_state_nxt = ST_FIN;
          end else if (i_op == OP_FILL) begin
            w_state_nxt    = ST_FILL;
            w_mem_we_nxt   = 1'b1;
            w_mem_addr_nxt = i_base;
            w_mem_din_nxt  = i_pattern;
          end else begin
            w_state_nxt    = ST_RD_ADDR;
            w_mem_addr_nxt = i_base;
            w_checksum_nxt = {DATA_W{1'b0}};
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (w_last) begin
          w_state_nxt  = ST_FIN;
          w_mem_we_nxt = 1'b0;
        end else begin
          w_idx_nxt      = w_idx_inc;
          w_mem_addr_nxt = w_addr_next_word;
          w_mem_din_nxt  = r_inc ? (r_mem_din + {{(DATA_W-1){1'b0}}, 1'b1}) : r_mem_din;
        end
      end

      ST_RD_ADDR: begin
        w_mem_we_nxt = 1'b0;
        w_state_nxt  = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        w_out_data_nxt  = i_mem_dout;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = ST_PRESENT;
      end

      ST_PRESENT: begin
        if (i_out_ready) begin
          w_checksum_nxt  = r_checksum + r_out_data;
          w_out_valid_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_idx_nxt      = w_idx_inc;
            w_mem_addr_nxt = w_addr_next_word;
            w_state_nxt    = ST_RD_ADDR;
          end
        end else begin
          w_state_nxt = ST_PRESENT;
        end
      end

      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_mem_we_nxt    = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_FIN);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_idx       <= {CNT_W{1'b0}};
      r_base      <= {ADDR_W{1'b0}};
      r_inc       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_din   <= {DATA_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_checksum  <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_base      <= w_base_nxt;
      r_inc       <= w_inc_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_din   <= w_mem_din_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_checksum  <= w_checksum_nxt;
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_din   = r_mem_din;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Scoreboard bench for ram_seq_ctrl with a 1-cycle-latency behavioural RAM.
module tb_ram_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  base = 8'h00;
  logic [8:0]  len = 9'd0;
  logic [15:0] pattern = 16'h0000;
  logic        inc_en = 1'b0;
  logic        out_ready = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = 16'h0000;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  ram_seq_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_op(op), .i_base(base),
    .i_len(len), .i_pattern(pattern), .i_inc_en(inc_en),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout), .o_out_data(out_data), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_busy(busy), .o_done(done), .o_checksum(checksum)
  );

  logic [15:0] ram     [256];
  logic [15:0] ref_mem [256];

  // RAM model: read-first, registered read data.
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_din;
  end

  int          checks = 0;
  int          errors = 0;
  logic [23:0] wr_q [$];
  logic [15:0] rd_q [$];
  int          words_seen = 0;
  int          wr_cnt = 0;
  int          stall_seen = 0;
  int          rdy_mode = 0;
  int          ws0 = 0;
  int          stall_left = 0;
  logic [15:0] exp_cs = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic        prev_rst = 1'b1;
  logic [15:0] prev_data = 16'h0000;
  logic [7:0]  prev_addr = 8'h00;

  // Monitor: pops the scoreboard for every write and every stream handshake.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write", mem_addr, mem_din);
      end else begin
        chk("write", {8'h00, mem_addr, mem_din}, {8'h00, wr_q.pop_front()});
      end
      wr_cnt++;
    end
    if (!reset && !prev_rst && prev_valid && !prev_hs) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {16'd0, out_data}, {16'd0, prev_data});
      chk("hold_ram_port", {23'd0, mem_we, mem_addr}, {24'd0, prev_addr});
    end
    if (out_valid && out_ready) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: data=0x%0h, expected no word", out_data);
      end else begin
        chk("dump_word", {16'd0, out_data}, {16'd0, rd_q.pop_front()});
      end
      words_seen++;
    end
    if (out_valid && !out_ready) stall_seen++;
    prev_valid = out_valid;
    prev_hs    = out_valid && out_ready;
    prev_data  = out_data;
    prev_addr  = mem_addr;
    prev_rst   = reset;
  end

  // Consumer ready: always, random, or a 10-cycle stall on the second word.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (($urandom % 3) != 0);
      default: begin
        if (out_valid && (words_seen - ws0 == 1) && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},       {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"},     {24'd0, mem_addr}, 32'd0);
    chk({tag, "_din"},      {16'd0, mem_din}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_valid"},    {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, done}, 32'd0);
    chk({tag, "_checksum"}, {16'd0, checksum}, 32'd0);
  endtask

  task automatic run_op(input logic o, input logic [7:0] b, input logic [8:0] l,
                        input logic [15:0] p, input logic ie, input int mode,
                        input logic fin_start, input logic poke);
    int cnt, n, lat, wr0;
    logic [7:0]  a;
    logic [15:0] d;
    cnt = (l > 9'd256) ? 256 : int'(l);
    if (o == 1'b0) begin
      for (int i = 0; i < cnt; i++) begin
        a = b + 8'(i);
        d = ie ? (p + 16'(i)) : p;
        ref_mem[a] = d;
        wr_q.push_back({a, d});
      end
    end else if (cnt > 0) begin
      exp_cs = 16'h0000;
      for (int i = 0; i < cnt; i++) begin
        a = b + 8'(i);
        rd_q.push_back(ref_mem[a]);
        exp_cs = exp_cs + ref_mem[a];
      end
    end
    lat = (o == 1'b0) ? cnt : 3 * cnt;
    rdy_mode = mode; ws0 = words_seen; stall_left = 10; wr0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = o; base = b; len = l; pattern = p; inc_en = ie;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); base = 8'($urandom); len = 9'($urandom);
    pattern = 16'($urandom); inc_en = 1'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 100) begin
        start = 1'b1; op = 1'b1; len = 9'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 4000 cycles, expected done");
    end else if (mode == 0) begin
      chk("done_latency", n, lat);
    end
    chk("busy_in_fin", {31'd0, busy}, 32'd1);
    if (fin_start) begin
      start = 1'b1; op = 1'b0; len = 9'd3; base = 8'h80;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("checksum", {16'd0, checksum}, {16'd0, exp_cs});
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_words", rd_q.size(), 0);
    if (o == 1'b0) chk("write_count", wr_cnt - wr0, cnt);
  endtask

  task automatic reset_mid_fill(input logic [7:0] b, input logic [15:0] p);
    logic [7:0] a;
    for (int i = 0; i < 3; i++) begin
      a = b + 8'(i);
      ref_mem[a] = p + 16'(i);
      wr_q.push_back({a, p + 16'(i)});
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; base = b; len = 9'd8; pattern = p; inc_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    reset = 1'b0;
    exp_cs = 16'h0000;
    @(posedge clk); #1;
    chk("post_reset_we", {31'd0, mem_we}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_pending", wr_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 8'h10, 9'd4, 16'h1234, 1'b1, 0, 1'b0, 1'b0);
    run_op(1'b1, 8'h10, 9'd4, 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    stall_seen = 0;
    run_op(1'b1, 8'h10, 9'd4, 16'h0000, 1'b0, 2, 1'b0, 1'b0);
    chk("stall_cycles", {31'd0, (stall_seen >= 10)}, 32'd1);
    run_op(1'b0, 8'hFE, 9'd4, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
    run_op(1'b1, 8'hFC, 9'd8, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
    run_op(1'b0, 8'h20, 9'd0, 16'hAAAA, 1'b1, 0, 1'b1, 1'b0);
    run_op(1'b1, 8'h20, 9'd0, 16'h0000, 1'b0, 0, 1'b1, 1'b0);
    run_op(1'b0, 8'h33, 9'd256, 16'h5A5A, 1'b0, 0, 1'b0, 1'b1);
    run_op(1'b0, 8'h90, 9'd40, 16'hFFF0, 1'b1, 0, 1'b0, 1'b0);
    reset_mid_fill(8'h40, 16'hC000);
    run_op(1'b1, 8'h3E, 9'd12, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      run_op(1'($urandom), 8'($urandom), 9'($urandom_range(0, 300)), 16'($urandom),
             1'($urandom), 1, 1'b0, 1'b0);
    end
    run_op(1'b0, 8'($urandom), 9'd511, 16'($urandom), 1'b1, 0, 1'b0, 1'b0);
    run_op(1'b1, 8'($urandom), 9'd300, 16'h0000, 1'b0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
